// File: rtl/keypad_debounce_enc.sv
// keypad_debounce_enc: synchronise, debounce and encode a single clean keypad press
module keypad_debounce_enc #(
  parameter int DB_CNT   = 50000,
  parameter int CNT_W    = 16,
  parameter int LONG_CNT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] keypad_in,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic        key_long,
  output logic        multi_err
);
  localparam int H_W = LONG_CNT > 0 ? $clog2(LONG_CNT + 1) : 1;
  typedef enum logic [1:0] {IDLE, DOWN, MULTI} state_t;
  state_t state_q, state_d;
  logic [11:0] sync1_q, sync_q, cand_q, stable_q;
  logic [CNT_W-1:0] cnt_q;
  logic [H_W-1:0] hold_q, hold_d;
  logic [3:0] code_q, code_d, idx;
  logic valid_q, valid_d, held_q, held_d, long_q, long_d, err_q, err_d;
  logic none, single, multi;
  // two-flop synchroniser, then accept a vector once it has stayed unchanged for DB_CNT cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync_q   <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= keypad_in;
      sync_q  <= sync1_q;
      cand_q  <= sync_q;
      if (sync_q != cand_q) cnt_q <= '0;
      else if (cnt_q != CNT_W'(DB_CNT - 1)) cnt_q <= cnt_q + 1'b1;
      else stable_q <= cand_q;
    end
  end
  assign none   = stable_q == 12'h000;
  assign single = !none && (stable_q & (stable_q - 12'd1)) == 12'h000;
  assign multi  = !none && !single;
  // position of the set bit; only meaningful when exactly one bit is set, so no priority needed
  always_comb begin
    idx = 4'd0;
    for (int i = 0; i < 12; i++) idx = stable_q[i] ? 4'(i) : idx;
  end
  // press-tracking FSM: next state plus next values of the registered outputs
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    hold_d  = hold_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (single) begin
          state_d = DOWN;
          code_d  = idx;
          valid_d = 1'b1;
          hold_d  = '0;
        end else if (multi) begin
          state_d = MULTI;
          err_d   = 1'b1;
        end
      end
      DOWN: begin
        if (none) state_d = IDLE;
        else if (multi) begin
          state_d = MULTI;
          err_d   = 1'b1;
        end else if (idx != code_q) state_d = MULTI;
        else hold_d = hold_q == H_W'(LONG_CNT) ? hold_q : hold_q + 1'b1;
      end
      MULTI:   state_d = none ? IDLE : MULTI;
      default: state_d = IDLE;
    endcase
    held_d = state_d == DOWN;
    long_d = LONG_CNT > 0 && state_d == DOWN && hold_d == H_W'(LONG_CNT);
  end
  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= 4'hF;
      hold_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      long_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      held_q  <= held_d;
      long_q  <= long_d;
      err_q   <= err_d;
    end
  end
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign key_long  = long_q;
  assign multi_err = err_q;
endmodule

// File: tb/tb_keypad_debounce_enc.sv
// tb_keypad_debounce_enc: directed and random keypad stimulus against a window-rule reference model
module tb_keypad_debounce_enc;
  localparam int DB   = 4;
  localparam int LONG = 8;
  typedef struct {bit err; logic [3:0] code; int cyc;} ev_t;
  typedef struct {string name; logic [7:0] act; logic [7:0] exp;} spot_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [11:0] keypad_in = '0;
  logic [3:0] key_code;
  logic key_valid, key_held, key_long, multi_err;
  ev_t ev_q[$];
  spot_t spot_q[$];
  int tests = 0, fails = 0, cyc = 0;
  bit done = 0;
  logic [11:0] h[8];
  logic [11:0] m_stable;
  int m_mode, m_hold;
  logic [3:0] m_code;
  logic exp_held, exp_long;

  keypad_debounce_enc #(.DB_CNT(DB), .CNT_W(4), .LONG_CNT(LONG)) dut (
    .clk(clk), .rst(rst), .keypad_in(keypad_in), .key_code(key_code),
    .key_valid(key_valid), .key_held(key_held), .key_long(key_long), .multi_err(multi_err));

  always #5 clk = ~clk;

  // reference: a vector counts as stable once the synchronised samples have been identical
  // for DB+1 consecutive samples; the press tracker reacts one edge after stability changes
  always @(posedge clk) begin
    int n;
    bit ok;
    cyc++;
    if (rst) begin
      for (int i = 0; i < 8; i++) h[i] = '0;
      m_stable = '0; m_mode = 0; m_hold = 0; m_code = 4'hF;
      exp_held = 0; exp_long = 0;
    end else begin
      n = $countones(m_stable);
      if (m_mode == 0) begin
        if (n == 1) begin
          m_mode = 1; m_hold = 0;
          for (int i = 0; i < 12; i++) if (m_stable == 12'(1 << i)) m_code = 4'(i);
          ev_q.push_back('{0, m_code, cyc});
        end else if (n > 1) begin
          m_mode = 2;
          ev_q.push_back('{1, 4'h0, cyc});
        end
      end else if (m_mode == 1) begin
        if (n == 0) m_mode = 0;
        else if (n > 1) begin
          m_mode = 2;
          ev_q.push_back('{1, 4'h0, cyc});
        end else if (m_stable != (12'd1 << m_code)) m_mode = 2;
        else m_hold++;
      end else if (n == 0) m_mode = 0;
      exp_held = m_mode == 1;
      exp_long = m_mode == 1 && m_hold >= LONG;
      ok = 1;
      for (int i = 2; i <= DB + 1; i++) if (h[i] != h[1]) ok = 0;
      if (ok) m_stable = h[1];
      for (int i = 7; i > 0; i--) h[i] = h[i-1];
      h[0] = keypad_in;
    end
  end

  // monitor: checks strobes against the event queue and levels against the model each cycle
  always @(posedge clk) begin
    ev_t e;
    spot_t s;
    #1;
    while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
      e = ev_q.pop_front();
      tests++; fails++;
      $display("FAIL missed_strobe cycle %0d: got none, required err=%0d code=%0d", e.cyc, e.err, e.code);
    end
    if (key_valid || multi_err) begin
      tests++;
      if (ev_q.size() == 0 || ev_q[0].cyc != cyc) begin
        fails++;
        $display("FAIL unexpected_strobe cycle %0d: got valid=%0b err=%0b, required none", cyc, key_valid, multi_err);
      end else begin
        e = ev_q.pop_front();
        if (key_valid !== !e.err || multi_err !== e.err || (!e.err && key_code !== e.code)) begin
          fails++;
          $display("FAIL strobe cycle %0d: got valid=%0b err=%0b code=%0d, required err=%0d code=%0d",
                   cyc, key_valid, multi_err, key_code, e.err, e.code);
        end
      end
    end
    tests++;
    if ({key_held, key_long, key_code} !== {exp_held, exp_long, m_code}) begin
      fails++;
      $display("FAIL levels cycle %0d: got held=%0b long=%0b code=%0h, required held=%0b long=%0b code=%0h",
               cyc, key_held, key_long, key_code, exp_held, exp_long, m_code);
    end
    while (spot_q.size() > 0) begin
      s = spot_q.pop_front();
      tests++;
      if (s.act !== s.exp) begin
        fails++;
        $display("FAIL %s: got %0h, required %0h", s.name, s.act, s.exp);
      end
    end
    if (done) begin
      tests++;
      if (ev_q.size() != 0) begin
        fails++;
        $display("FAIL pending_events: got %0d left, required 0", ev_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold(input logic [11:0] v, input int n);
    keypad_in = v;
    step(n);
  endtask

  task automatic spot(input string name, input logic [7:0] act, input logic [7:0] exp);
    spot_q.push_back('{name, act, exp});
  endtask

  initial begin
    int a, b, r;
    rst = 1; keypad_in = '0;
    step(2);
    rst = 0;
    spot("rst_code", 8'(key_code), 8'hF);
    spot("rst_strobes", {6'd0, key_valid, multi_err}, 8'd0);
    spot("rst_levels", {6'd0, key_held, key_long}, 8'd0);
    hold(12'd1 << 5, 20);
    spot("k5_code", 8'(key_code), 8'd5);
    spot("k5_held", 8'(key_held), 8'd1);
    hold('0, 12);
    spot("k5_release_held", 8'(key_held), 8'd0);
    spot("k5_release_code", 8'(key_code), 8'd5);
    repeat (3) begin hold(12'd1 << 9, 2); hold('0, 2); end
    hold(12'd1 << 9, 15);
    spot("k9_code", 8'(key_code), 8'd9);
    hold('0, 12);
    hold((12'd1 << 2) | (12'd1 << 7), 15);
    hold(12'd1 << 7, 15);
    spot("chord_code", 8'(key_code), 8'd9);
    hold('0, 12);
    hold(12'd1 << 7, 15);
    spot("k7_code", 8'(key_code), 8'd7);
    hold('0, 12);
    hold(12'd1, 30);
    spot("k0_long", 8'(key_long), 8'd1);
    hold('0, 12);
    spot("k0_long_rel", 8'(key_long), 8'd0);
    hold(12'd1 << 11, 15);
    rst = 1;
    step(1);
    rst = 0;
    spot("midrst_code", 8'(key_code), 8'hF);
    spot("midrst_held", 8'(key_held), 8'd0);
    step(15);
    spot("k11_code", 8'(key_code), 8'd11);
    hold('0, 12);
    repeat (150) begin
      r = $urandom_range(0, 9);
      a = $urandom_range(0, 11);
      b = (a + $urandom_range(1, 11)) % 12;
      if (r < 4) hold('0, $urandom_range(1, 14));
      else if (r < 8) hold(12'd1 << a, $urandom_range(1, 14));
      else if (r == 8) hold((12'd1 << a) | (12'd1 << b), $urandom_range(1, 14));
      else repeat ($urandom_range(1, 4)) begin
        hold(12'd1 << a, $urandom_range(1, 3));
        hold('0, $urandom_range(1, 3));
      end
      if ($urandom_range(0, 39) == 0) begin
        rst = 1;
        step($urandom_range(1, 2));
        rst = 0;
      end
    end
    hold('0, 15);
    done = 1;
    step(20);
    $display("FAIL timeout: monitor did not finish");
    $fatal(1);
  end
endmodule
